// File: rtl/multi_channel_stopwatch_timer.sv
// multi_channel_stopwatch_timer: NUM_CH stopwatch/countdown channels on one tick prescaler.
// Optional STOPWATCH_AUTO_RELOAD_EN: countdown expiry reloads and pulses ringSound instead of latching.
module multi_channel_stopwatch_timer #(
  parameter int NUM_CH   = 2,
  parameter int COUNT_W  = 32,
  parameter int TICK_DIV = 1000000,
  parameter int CH_W     = 3
) (
  input  logic                        clockSignal,
  input  logic                        resetN,
  input  logic                        cmdValid,
  input  logic [CH_W-1:0]             cmdChannel,
  input  logic [2:0]                  cmdOp,
  input  logic [COUNT_W-1:0]          cmdData,
  output logic [NUM_CH*COUNT_W-1:0]   countFlat,
  output logic [NUM_CH*COUNT_W-1:0]   lapFlat,
  output logic [NUM_CH-1:0]           lapValid,
  output logic [NUM_CH-1:0]           running,
  output logic [NUM_CH-1:0]           ringSound,
  output logic                        tickPulse
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_SPLIT = 3'd2;
  localparam logic [2:0] OP_LOAD  = 3'd3;
  localparam logic [2:0] OP_MODE  = 3'd4;
  localparam logic [2:0] OP_ACK   = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  logic [DIV_W-1:0] divCnt;
  logic isStart;
  logic isSplit;
  logic isLoad;
  logic isMode;
  logic isAck;

  // free-running centisecond prescaler
  always_ff @(posedge clockSignal) begin
    if (!resetN) begin
      divCnt <= '0;
    end else if (divCnt == DIV_LAST) begin
      divCnt <= '0;
    end else begin
      divCnt <= divCnt + DIV_W'(1);
    end
  end

  assign tickPulse = (divCnt == DIV_LAST);

  assign isStart = (cmdOp == OP_START);
  assign isSplit = (cmdOp == OP_SPLIT);
  assign isLoad  = (cmdOp == OP_LOAD);
  assign isMode  = (cmdOp == OP_MODE);
  assign isAck   = (cmdOp == OP_ACK);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    localparam logic [CH_W-1:0] ID = CH_W'(i);

    state_t st;
    state_t stN;
    logic mode;
    logic modeN;
    logic [COUNT_W-1:0] cnt;
    logic [COUNT_W-1:0] cntN;
    logic [COUNT_W-1:0] rld;
    logic [COUNT_W-1:0] rldN;
    logic [COUNT_W-1:0] lap;
    logic [COUNT_W-1:0] lapN;
    logic lv;
    logic lvN;
    logic ring;
    logic ringN;
    logic hit;
    logic tickOk;
    logic reloadHit;

    assign hit = cmdValid && (cmdChannel == ID);

    // state register
    always_ff @(posedge clockSignal) begin
      if (!resetN) begin
        st <= IDLE;
      end else begin
        st <= stN;
      end
    end

    // channel datapath registers
    always_ff @(posedge clockSignal) begin
      if (!resetN) begin
        mode <= 1'b0;
        cnt  <= '0;
        rld  <= '0;
        lap  <= '0;
        lv   <= 1'b0;
        ring <= 1'b0;
      end else begin
        mode <= modeN;
        cnt  <= cntN;
        rld  <= rldN;
        lap  <= lapN;
        lv   <= lvN;
        ring <= ringN;
      end
    end

    // command decode, then tick arithmetic unless a command claimed the cycle
    always_comb begin
      stN       = st;
      modeN     = mode;
      cntN      = cnt;
      rldN      = rld;
      lapN      = lap;
      lvN       = lv;
      reloadHit = 1'b0;
      tickOk    = tickPulse && (st == RUN);

      if (hit) begin
        unique case (1'b1)
          isStart: begin
            unique case (st)
              IDLE: begin
                if (!(mode && (cnt == '0))) begin
                  stN = RUN;
                end
              end
              RUN: begin
                stN    = PAUSE;
                tickOk = 1'b0;
              end
              PAUSE:   stN = RUN;
              default: ;
            endcase
          end
          isSplit: begin
            if (st == RUN) begin
              lapN = cnt;
              lvN  = 1'b1;
            end else begin
              stN  = IDLE;
              cntN = rld;
              lapN = '0;
              lvN  = 1'b0;
            end
          end
          isLoad: begin
            if (mode && ((st == IDLE) || (st == PAUSE))) begin
              rldN = cmdData;
              cntN = cmdData;
            end
          end
          isMode: begin
            if (st == IDLE) begin
              modeN = cmdData[0];
              cntN  = '0;
              rldN  = '0;
              lapN  = '0;
              lvN   = 1'b0;
            end
          end
          isAck: begin
            if (st == EXPIRED) begin
              stN = IDLE;
            end
          end
          default: ;
        endcase
      end

      if (tickOk) begin
        if (!mode) begin
          if (cnt != CNT_MAX) begin
            cntN = cnt + CNT_ONE;
          end
        end else if (cnt == CNT_ONE) begin
`ifdef STOPWATCH_AUTO_RELOAD_EN
          if (rld != '0) begin
            cntN      = rld;
            reloadHit = 1'b1;
          end else begin
            cntN = '0;
            stN  = EXPIRED;
          end
`else
          cntN = '0;
          stN  = EXPIRED;
`endif
        end else if (cnt != '0) begin
          cntN = cnt - CNT_ONE;
        end
      end

      ringN = (stN == EXPIRED) || reloadHit;
    end

    assign countFlat[i*COUNT_W +: COUNT_W] = cnt;
    assign lapFlat[i*COUNT_W +: COUNT_W]   = lap;
    assign lapValid[i]  = lv;
    assign running[i]   = (st == RUN);
    assign ringSound[i] = ring;
  end

endmodule

// File: tb/tb_multi_channel_stopwatch_timer.sv
// tb_multi_channel_stopwatch_timer: directed stimulus with a spec-level model
// compared every cycle, plus literal checks pinning key values.
module tb_multi_channel_stopwatch_timer;

  localparam int NCH  = 2;
  localparam int CW   = 16;
  localparam int DIV  = 4;
  localparam int CHW  = 3;
  localparam int MAXV = 65535;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_EXP   = 3;

  logic clk;
  logic resetN;
  logic cmdValid;
  logic [CHW-1:0] cmdChannel;
  logic [2:0] cmdOp;
  logic [CW-1:0] cmdData;
  logic [NCH*CW-1:0] countFlat;
  logic [NCH*CW-1:0] lapFlat;
  logic [NCH-1:0] lapValid;
  logic [NCH-1:0] running;
  logic [NCH-1:0] ringSound;
  logic tickPulse;

  multi_channel_stopwatch_timer #(
    .NUM_CH(NCH),
    .COUNT_W(CW),
    .TICK_DIV(DIV),
    .CH_W(CHW)
  ) dut (
    .clockSignal(clk),
    .resetN(resetN),
    .cmdValid(cmdValid),
    .cmdChannel(cmdChannel),
    .cmdOp(cmdOp),
    .cmdData(cmdData),
    .countFlat(countFlat),
    .lapFlat(lapFlat),
    .lapValid(lapValid),
    .running(running),
    .ringSound(ringSound),
    .tickPulse(tickPulse)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  int mst[NCH];
  int mcnt[NCH];
  int mrld[NCH];
  int mlap[NCH];
  bit mlv[NCH];
  bit mdown[NCH];
  bit mpulse[NCH];
  int cycles_since_tick;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit tick;
    bit was_run;
    bit drop;
    if (!resetN) begin
      for (int c = 0; c < NCH; c++) begin
        mst[c] = S_IDLE;
        mcnt[c] = 0;
        mrld[c] = 0;
        mlap[c] = 0;
        mlv[c] = 0;
        mdown[c] = 0;
        mpulse[c] = 0;
      end
      cycles_since_tick = 0;
      return;
    end
    tick = (cycles_since_tick == DIV - 1);
    for (int c = 0; c < NCH; c++) begin
      was_run = (mst[c] == S_RUN);
      drop = 0;
      mpulse[c] = 0;
      if (cmdValid && int'(cmdChannel) == c) begin
        case (int'(cmdOp))
          1: begin
            if (mst[c] == S_IDLE && !(mdown[c] && mcnt[c] == 0)) mst[c] = S_RUN;
            else if (mst[c] == S_RUN) begin
              mst[c] = S_PAUSE;
              drop = 1;
            end else if (mst[c] == S_PAUSE) mst[c] = S_RUN;
          end
          2: begin
            if (was_run) begin
              mlap[c] = mcnt[c];
              mlv[c] = 1;
            end else begin
              mst[c] = S_IDLE;
              mcnt[c] = mrld[c];
              mlap[c] = 0;
              mlv[c] = 0;
            end
          end
          3: begin
            if (mdown[c] && (mst[c] == S_IDLE || mst[c] == S_PAUSE)) begin
              mrld[c] = int'(cmdData);
              mcnt[c] = int'(cmdData);
            end
          end
          4: begin
            if (mst[c] == S_IDLE) begin
              mdown[c] = cmdData[0];
              mcnt[c] = 0;
              mrld[c] = 0;
              mlap[c] = 0;
              mlv[c] = 0;
            end
          end
          5: if (mst[c] == S_EXP) mst[c] = S_IDLE;
          default: ;
        endcase
      end
      if (tick && was_run && !drop) begin
        if (!mdown[c]) begin
          mcnt[c] = (mcnt[c] + 1 > MAXV) ? MAXV : mcnt[c] + 1;
        end else if (mcnt[c] > 0) begin
          mcnt[c] = mcnt[c] - 1;
          if (mcnt[c] == 0) begin
`ifdef STOPWATCH_AUTO_RELOAD_EN
            if (mrld[c] != 0) begin
              mcnt[c] = mrld[c];
              mpulse[c] = 1;
            end else begin
              mst[c] = S_EXP;
            end
`else
            mst[c] = S_EXP;
`endif
          end
        end
      end
    end
    cycles_since_tick = (cycles_since_tick + 1) % DIV;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int c = 0; c < NCH; c++) begin
          chk($sformatf("m_count%0d", c), 64'(countFlat[c*CW +: CW]), 64'(mcnt[c]));
          chk($sformatf("m_lap%0d", c), 64'(lapFlat[c*CW +: CW]), 64'(mlap[c]));
          chk($sformatf("m_lapValid%0d", c), 64'(lapValid[c]), 64'(mlv[c]));
          chk($sformatf("m_running%0d", c), 64'(running[c]), 64'(mst[c] == S_RUN));
          chk($sformatf("m_ring%0d", c), 64'(ringSound[c]),
              64'((mst[c] == S_EXP) || mpulse[c]));
        end
        chk("m_tick", 64'(tickPulse), 64'(cycles_since_tick == DIV - 1));
      end
    end
  end

  task automatic cmd(int ch, int op, int data);
    cmdValid = 1'b1;
    cmdChannel = CHW'(ch);
    cmdOp = 3'(op);
    cmdData = CW'(data);
    @(negedge clk);
    cmdValid = 1'b0;
    cmdChannel = '0;
    cmdOp = '0;
    cmdData = '0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    resetN = 1'b1;
  endtask

  function automatic int cnt_of(int ch);
    return int'(countFlat[ch*CW +: CW]);
  endfunction

  task automatic wait_count(int ch, int val);
    int n;
    n = 0;
    while (cnt_of(ch) != val && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) chk($sformatf("wait_count%0d", ch), 64'(cnt_of(ch)), 64'(val));
  endtask

  initial begin
    int n;
    int pulses;
    resetN = 1'b0;
    cmdValid = 1'b0;
    cmdChannel = '0;
    cmdOp = '0;
    cmdData = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1;
    chk("rst_count", 64'(countFlat), 64'(0));
    chk("rst_running", 64'(running), 64'(0));
    chk("rst_tick", 64'(tickPulse), 64'(0));
    resetN = 1'b1;

    cmd(0, 1, 0);
    chk("start_running", 64'(running), 64'(2'b01));
    repeat (40) @(negedge clk);
    chk("ten_ticks", 64'(cnt_of(0)), 64'(10));
    chk("ch1_idle_count", 64'(cnt_of(1)), 64'(0));

    do_reset();
    cmd(0, 1, 0);
    wait_count(0, 7);
    cmd(0, 2, 0);
    chk("lap_val", 64'(lapFlat[0 +: CW]), 64'(7));
    chk("lap_valid", 64'(lapValid), 64'(2'b01));
    chk("lap_still_run", 64'(running), 64'(2'b01));
    repeat (9) @(negedge clk);
    cmd(0, 1, 0);
    chk("pause_running", 64'(running), 64'(0));
    cmd(0, 2, 0);
    chk("clr_count", 64'(cnt_of(0)), 64'(0));
    chk("clr_lap", 64'(lapFlat[0 +: CW]), 64'(0));
    chk("clr_lapValid", 64'(lapValid), 64'(0));

    cmd(1, 4, 1);
    cmd(1, 3, 3);
    chk("load_count", 64'(cnt_of(1)), 64'(3));
    cmd(1, 1, 0);
    wait_count(1, 0);
    chk("expire_ring", 64'(ringSound), 64'(2'b10));
    chk("expire_stop", 64'(running), 64'(0));
    repeat (12) @(negedge clk);
    chk("expire_hold", 64'(cnt_of(1)), 64'(0));
    chk("expire_ring_hold", 64'(ringSound), 64'(2'b10));
    cmd(1, 5, 0);
    chk("ack_ring", 64'(ringSound), 64'(0));
    chk("ack_count", 64'(cnt_of(1)), 64'(0));
    cmd(1, 1, 0);
    chk("start_zero_ignored", 64'(running), 64'(0));

    do_reset();
    force dut.g_ch[0].cnt = 16'hFFFD;
    mcnt[0] = 16'hFFFD;
    @(negedge clk);
    @(negedge clk);
    release dut.g_ch[0].cnt;
    cmd(0, 1, 0);
    wait_count(0, MAXV);
    repeat (12) @(negedge clk);
    chk("sat_count", 64'(cnt_of(0)), 64'(16'hFFFF));
    chk("sat_running", 64'(running), 64'(2'b01));
    cmd(2, 1, 0);
    cmd(2, 2, 0);
    chk("badch_running", 64'(running), 64'(2'b01));
    chk("badch_lapValid", 64'(lapValid), 64'(0));

    do_reset();
    cmd(0, 1, 0);
    wait_count(0, 2);
    n = 0;
    while (!tickPulse && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("tick_seen", 64'(tickPulse), 64'(1));
    cmd(0, 1, 0);
    chk("stop_on_tick_count", 64'(cnt_of(0)), 64'(2));
    chk("stop_on_tick_run", 64'(running), 64'(0));
    cmd(1, 4, 1);
    cmd(1, 3, 50);
    cmd(1, 1, 0);
    repeat (10) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    chk("midrst_count", 64'(countFlat), 64'(0));
    chk("midrst_lap", 64'({lapFlat, lapValid}), 64'(0));
    chk("midrst_flags", 64'({running, ringSound, tickPulse}), 64'(0));
    resetN = 1'b1;

`ifdef STOPWATCH_AUTO_RELOAD_EN
    @(negedge clk);
    cmd(1, 4, 1);
    cmd(1, 3, 2);
    cmd(1, 1, 0);
    pulses = 0;
    n = 0;
    repeat (24) begin
      @(negedge clk);
      if (ringSound[1]) pulses++;
      if (!running[1]) n++;
    end
    chk("auto_pulses", 64'(pulses), 64'(3));
    chk("auto_not_running_cycles", 64'(n), 64'(0));
`else
    pulses = 0;
`endif
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
